// File: rtl/icache_line_fill_if.sv
// Bundles the per-beat inputs from the AHB transfer handler with the line and critical-word outputs of
// the I-cache line-fill stage.
interface icache_line_fill_if #(
  parameter int LINE_WORDS = 4
);
  logic [1:0]               trans_in;
  logic [31:0]              beat_addr;
  logic [31:0]              beat_data;
  logic                     beat_valid;
  logic                     flush;
  logic                     line_ready;
  logic                     crit_valid;
  logic [31:0]              crit_addr;
  logic [31:0]              crit_data;
  logic                     line_valid;
  logic [31:0]              line_addr;
  logic [32*LINE_WORDS-1:0] line_data;
  logic                     busy;
  logic                     fill_err;

  // Handshake: a beat transfers on a rising clk edge when beat_valid=1 and trans_in is NONSEQ or SEQ.
  // The line transfers on an edge where line_valid=1 and line_ready=1.
  modport slave (
    input  trans_in, beat_addr, beat_data, beat_valid, flush, line_ready,
    output crit_valid, crit_addr, crit_data, line_valid, line_addr, line_data, busy, fill_err
  );

  modport master (
    output trans_in, beat_addr, beat_data, beat_valid, flush, line_ready,
    input  crit_valid, crit_addr, crit_data, line_valid, line_addr, line_data, busy, fill_err
  );
endinterface

// File: rtl/icache_line_fill.sv
// Assembles a WRAP4 burst into a 128-bit I-cache line, delivered critical-word-first.
// The critical word is forwarded on a single-cycle pulse.
module icache_line_fill #(
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  icache_line_fill_if.slave     bus,
  output logic [1:0]            dbg_state_o,
  output logic [2:0]            dbg_count_o,
  output logic [LINE_WORDS-1:0] dbg_mask_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 base_q, base_d;
  logic [1:0]                  idx_q, idx_d;
  logic [2:0]                  count_q, count_d;
  logic [LINE_WORDS-1:0]       mask_q, mask_d;
  logic [LINE_WORDS-1:0][31:0] words_q, words_d;
  logic                        crit_valid_q, crit_valid_d;
  logic [31:0]                 crit_addr_q, crit_addr_d;
  logic [31:0]                 crit_data_q, crit_data_d;
  logic                        err_q, err_d;
  logic                        busy_q, line_valid_q;
  logic                        start_fill;

  logic       accept, is_nonseq, seq_ok, last_beat;
  logic [1:0] idx_exp;
  logic       unused_addr_lsb;

  assign accept    = bus.beat_valid && bus.trans_in[1];
  assign is_nonseq = (bus.trans_in == 2'd2);
  assign idx_exp   = idx_q + 2'd1;
  assign seq_ok    = (bus.trans_in == 2'd3) && (bus.beat_addr[31:4] == base_q[31:4]) &&
                     (bus.beat_addr[3:2] == idx_exp);
  assign last_beat = (count_q + 3'd1) == 3'(LINE_WORDS);
  assign unused_addr_lsb = ^bus.beat_addr[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      count_q      <= '0;
      mask_q       <= '0;
      words_q      <= '0;
      crit_valid_q <= 1'b0;
      crit_addr_q  <= '0;
      crit_data_q  <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      mask_q       <= mask_d;
      words_q      <= words_d;
      crit_valid_q <= crit_valid_d;
      crit_addr_q  <= crit_addr_d;
      crit_data_q  <= crit_data_d;
      err_q        <= err_d;
      busy_q       <= (state_d != S_IDLE);
      line_valid_q <= (state_d == S_DONE);
    end
  end

  // Flush overrides every beat and handshake event.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept && is_nonseq) state_d = S_FILL;
        S_FILL: begin
          if (accept) begin
            if (is_nonseq)      state_d = S_FILL;
            else if (!seq_ok)   state_d = S_IDLE;
            else if (last_beat) state_d = S_DONE;
          end
        end
        S_DONE: if (bus.line_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    base_d       = base_q;
    idx_d        = idx_q;
    count_d      = count_q;
    mask_d       = mask_q;
    words_d      = words_q;
    crit_valid_d = 1'b0;
    crit_addr_d  = crit_addr_q;
    crit_data_d  = crit_data_q;
    err_d        = 1'b0;
    start_fill   = 1'b0;
    if (bus.flush) begin
      mask_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_nonseq) start_fill = 1'b1;
            else           err_d      = 1'b1;
          end
        end
        S_FILL: begin
          if (accept) begin
            if (is_nonseq) begin
              err_d      = 1'b1;
              start_fill = 1'b1;
            end else if (seq_ok) begin
              words_d[idx_exp] = bus.beat_data;
              mask_d[idx_exp]  = 1'b1;
              count_d          = count_q + 3'd1;
              idx_d            = idx_exp;
            end else begin
              err_d   = 1'b1;
              mask_d  = '0;
              count_d = '0;
            end
          end
        end
        S_DONE: begin
          if (bus.line_ready) begin
            mask_d  = '0;
            count_d = '0;
          end
          if (accept) err_d = 1'b1;
        end
        default: ;
      endcase
    end
    // A new NONSEQ restarts the line from scratch, discarding any partial mask.
    if (start_fill) begin
      base_d                          = {bus.beat_addr[31:4], 4'h0};
      idx_d                           = bus.beat_addr[3:2];
      words_d[bus.beat_addr[3:2]]     = bus.beat_data;
      mask_d                          = '0;
      mask_d[bus.beat_addr[3:2]]      = 1'b1;
      count_d                         = 3'd1;
      crit_valid_d                    = 1'b1;
      crit_addr_d                     = bus.beat_addr;
      crit_data_d                     = bus.beat_data;
    end
  end

  always_comb begin
    bus.crit_valid = crit_valid_q;
    bus.crit_addr  = crit_addr_q;
    bus.crit_data  = crit_data_q;
    bus.line_valid = line_valid_q;
    bus.line_addr  = base_q;
    bus.line_data  = words_q;
    bus.busy       = busy_q;
    bus.fill_err   = err_q;
    dbg_state_o    = state_q;
    dbg_count_o    = count_q;
    dbg_mask_o     = mask_q;
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: WRAP4 fills, wait states, line hold, protocol errors, flush and
// asynchronous reset.
module tb_icache_line_fill;
  localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;

  logic       clk;
  logic       rstn;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;
  logic [3:0] dbg_mask;
  int         total;
  int         bad;
  logic [127:0] held;

  icache_line_fill_if bus ();

  icache_line_fill dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count),
    .dbg_mask_o  (dbg_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic step(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d, input logic v);
    bus.trans_in   = t;
    bus.beat_addr  = a;
    bus.beat_data  = d;
    bus.beat_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    step(T_IDLE, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus.trans_in = T_IDLE; bus.beat_addr = '0; bus.beat_data = '0; bus.beat_valid = 1'b0;
    bus.flush = 1'b0; bus.line_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_crit_valid", bus.crit_valid, 0);
    chk("rst_crit_addr",  bus.crit_addr, 0);
    chk("rst_line_valid", bus.line_valid, 0);
    chk("rst_line_data",  bus.line_data, 0);
    chk("rst_busy",       bus.busy, 0);
    chk("rst_fill_err",   bus.fill_err, 0);
    chk("rst_state",      dbg_state, 0);
    rstn = 1'b1;
    idle_cyc();

    // SEQ with no fill in progress
    step(T_SEQ, 32'h0000_0F04, 32'h1111_1111, 1'b1);
    chk("idle_seq_err",   bus.fill_err, 1);
    chk("idle_seq_state", dbg_state, 0);
    idle_cyc();
    chk("err_pulse_end",  bus.fill_err, 0);

    // WRAP4 from 0x1008
    step(T_NSEQ, 32'h0000_1008, 32'hAAAA_0001, 1'b1);
    chk("t1_crit_valid", bus.crit_valid, 1);
    chk("t1_crit_addr",  bus.crit_addr, 32'h0000_1008);
    chk("t1_crit_data",  bus.crit_data, 32'hAAAA_0001);
    chk("t1_busy",       bus.busy, 1);
    step(T_SEQ, 32'h0000_100C, 32'hBBBB_0002, 1'b1);
    chk("t1_crit_pulse", bus.crit_valid, 0);
    step(T_SEQ, 32'h0000_1000, 32'hCCCC_0003, 1'b1);
    chk("t1_count3",     dbg_count, 3);
    chk("t1_not_yet",    bus.line_valid, 0);
    step(T_SEQ, 32'h0000_1004, 32'hDDDD_0004, 1'b1);
    chk("t1_line_valid", bus.line_valid, 1);
    chk("t1_line_addr",  bus.line_addr, 32'h0000_1000);
    chk("t1_line_data",  bus.line_data, {32'hBBBB_0002, 32'hAAAA_0001, 32'hDDDD_0004, 32'hCCCC_0003});
    idle_cyc();
    chk("t1_idle_state", dbg_state, 0);
    chk("t1_busy_low",   bus.busy, 0);
    chk("t1_lv_low",     bus.line_valid, 0);
    chk("t1_mask_clr",   dbg_mask, 0);

    // WRAP4 from 0x2000 with wait states and a held line
    bus.line_ready = 1'b0;
    step(T_NSEQ, 32'h0000_2000, 32'hE000_0000, 1'b1);
    step(T_SEQ,  32'h0000_2004, 32'hE000_0001, 1'b1);
    idle_cyc();
    idle_cyc();
    chk("t2_wait_busy",  bus.busy, 1);
    chk("t2_wait_count", dbg_count, 2);
    step(T_SEQ,  32'h0000_2008, 32'hE000_0002, 1'b1);
    step(T_SEQ,  32'h0000_200C, 32'hE000_0003, 1'b1);
    chk("t2_line_valid", bus.line_valid, 1);
    chk("t2_line_addr",  bus.line_addr, 32'h0000_2000);
    chk("t2_line_data",  bus.line_data, {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000});
    held = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
    idle_cyc();
    chk("t2_hold1_data", bus.line_data, held);
    chk("t2_hold1_busy", bus.busy, 1);
    step(T_SEQ, 32'h0000_2010, 32'hDEAD_BEEF, 1'b1);
    chk("t2_done_err",   bus.fill_err, 1);
    chk("t2_hold2_data", bus.line_data, held);
    chk("t2_hold2_addr", bus.line_addr, 32'h0000_2000);
    idle_cyc();
    chk("t2_hold3_lv",   bus.line_valid, 1);
    chk("t2_hold3_busy", bus.busy, 1);
    chk("t2_hold3_err",  bus.fill_err, 0);
    bus.line_ready = 1'b1;
    idle_cyc();
    chk("t2_rel_busy",   bus.busy, 0);
    chk("t2_rel_lv",     bus.line_valid, 0);

    // Out-of-order SEQ
    step(T_NSEQ, 32'h0000_3004, 32'h3333_0001, 1'b1);
    step(T_SEQ,  32'h0000_300C, 32'h3333_0003, 1'b1);
    chk("t3_err",        bus.fill_err, 1);
    chk("t3_state",      dbg_state, 0);
    chk("t3_lv",         bus.line_valid, 0);
    chk("t3_mask",       dbg_mask, 0);
    idle_cyc();
    chk("t3_busy",       bus.busy, 0);

    // NONSEQ restart in mid-fill
    step(T_NSEQ, 32'h0000_5000, 32'h5555_0000, 1'b1);
    step(T_SEQ,  32'h0000_5004, 32'h5555_0001, 1'b1);
    step(T_NSEQ, 32'h0000_4000, 32'h4444_0000, 1'b1);
    chk("t4_err",        bus.fill_err, 1);
    chk("t4_crit_valid", bus.crit_valid, 1);
    chk("t4_crit_addr",  bus.crit_addr, 32'h0000_4000);
    chk("t4_count",      dbg_count, 1);
    chk("t4_mask",       dbg_mask, 4'b0001);
    step(T_SEQ,  32'h0000_4004, 32'h4444_0001, 1'b1);
    step(T_SEQ,  32'h0000_4008, 32'h4444_0002, 1'b1);
    step(T_SEQ,  32'h0000_400C, 32'h4444_0003, 1'b1);
    chk("t4_line_valid", bus.line_valid, 1);
    chk("t4_line_addr",  bus.line_addr, 32'h0000_4000);
    chk("t4_line_data",  bus.line_data, {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000});
    idle_cyc();

    // Flush after three beats, dropping a beat in the flush cycle
    step(T_NSEQ, 32'h0000_6000, 32'h6666_0000, 1'b1);
    step(T_SEQ,  32'h0000_6004, 32'h6666_0001, 1'b1);
    step(T_SEQ,  32'h0000_6008, 32'h6666_0002, 1'b1);
    bus.flush = 1'b1;
    step(T_SEQ,  32'h0000_600C, 32'h6666_0003, 1'b1);
    bus.flush = 1'b0;
    chk("t5_state",      dbg_state, 0);
    chk("t5_busy",       bus.busy, 0);
    chk("t5_lv",         bus.line_valid, 0);
    chk("t5_err",        bus.fill_err, 0);
    chk("t5_count",      dbg_count, 0);
    step(T_NSEQ, 32'h0000_7004, 32'h7777_0001, 1'b1);
    step(T_SEQ,  32'h0000_7008, 32'h7777_0002, 1'b1);
    step(T_SEQ,  32'h0000_700C, 32'h7777_0003, 1'b1);
    step(T_SEQ,  32'h0000_7000, 32'h7777_0000, 1'b1);
    chk("t5_line_valid", bus.line_valid, 1);
    chk("t5_line_addr",  bus.line_addr, 32'h0000_7000);
    chk("t5_line_data",  bus.line_data, {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000});
    idle_cyc();

    // Asynchronous reset in the middle of a fill
    step(T_NSEQ, 32'h0000_8008, 32'h8888_0002, 1'b1);
    step(T_SEQ,  32'h0000_800C, 32'h8888_0003, 1'b1);
    bus.beat_valid = 1'b0;
    bus.trans_in   = T_IDLE;
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_busy",   bus.busy, 0);
    chk("t6_rst_crit",   bus.crit_addr, 0);
    chk("t6_rst_cdata",  bus.crit_data, 0);
    chk("t6_rst_ldata",  bus.line_data, 0);
    chk("t6_rst_laddr",  bus.line_addr, 0);
    chk("t6_rst_state",  dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    step(T_NSEQ, 32'h0000_9000, 32'h9999_0000, 1'b1);
    chk("t6_crit_data",  bus.crit_data, 32'h9999_0000);
    step(T_SEQ,  32'h0000_9004, 32'h9999_0001, 1'b1);
    step(T_SEQ,  32'h0000_9008, 32'h9999_0002, 1'b1);
    step(T_SEQ,  32'h0000_900C, 32'h9999_0003, 1'b1);
    chk("t6_line_valid", bus.line_valid, 1);
    chk("t6_line_addr",  bus.line_addr, 32'h0000_9000);
    chk("t6_line_data",  bus.line_data, {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000});
    idle_cyc();
    chk("t6_end_state",  dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
